// File: rtl/alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ctrl_sequencer
//
// Hardwired control unit for the DataPath. It steps one instruction through
// T0..T6: fetch, then a register-register ALU operation. While it does so it
// drives the bus source selects, register load enables, PC increment, memory
// read and ALU enable. It also counts retired instructions.
//
// Ports:
//   w_clock      : system clock, all state changes on its rising edge
//   w_clear      : synchronous active-high reset (wins over w_run)
//   w_run        : start/continue request, sampled in IDLE and at instr end
//   w_IR         : IR contents; [31:27] opcode, [26:23] ra, [22:19] rb,
//                  [18:15] rc. Valid from T3 onwards.
//   s_PC, s_Zlow, s_Zhigh, s_MDR : single-bit bus source selects
//   s_Rout       : one-hot register bus source select
//   e_Rin        : one-hot register write enable
//   e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO : register load enables
//   w_IncPC, w_read, e_alu : PC increment, memory read, ALU enable
//   opcode       : ALU operation {1'b0, w_IR[31:27]}, driven only in T4
//   busy         : high in every state except IDLE and ILLEGAL
//   done         : one-cycle pulse in the final T-state of an instruction
//   illegal      : high while parked in ILLEGAL
//   instr_count  : retired-instruction count, wraps modulo 2^CNT_W
//
// All outputs are a combinational decode of the state register and the IR
// fields. They therefore only move after a clock edge.
// -----------------------------------------------------------------------------
module alu_ctrl_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                w_clock,
    input  logic                w_clear,
    input  logic                w_run,
    input  logic [31:0]         w_IR,
    output logic                s_PC,
    output logic                s_Zlow,
    output logic                s_Zhigh,
    output logic                s_MDR,
    output logic [NUM_REGS-1:0] s_Rout,
    output logic [NUM_REGS-1:0] e_Rin,
    output logic                e_MAR,
    output logic                e_Z,
    output logic                e_PC,
    output logic                e_MDR,
    output logic                e_IR,
    output logic                e_Y,
    output logic                e_HI,
    output logic                e_LO,
    output logic                w_IncPC,
    output logic                w_read,
    output logic                e_alu,
    output logic [5:0]          opcode,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_T0      = 4'd1,
        ST_T1      = 4'd2,
        ST_T2      = 4'd3,
        ST_T3      = 4'd4,
        ST_T4      = 4'd5,
        ST_T5      = 4'd6,
        ST_T6      = 4'd7,
        ST_ILLEGAL = 4'd8
    } state_t;

    localparam logic [4:0] OP_NOT = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b00101;
    localparam logic [4:0] OP_DIV = 5'b00110;
    localparam logic [4:0] OP_NEG = 5'b01100;
    localparam logic [4:0] OP_MAX = 5'b01100;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;

    // IR field extraction
    logic [4:0] ir_op;
    logic [3:0] ir_ra;
    logic [3:0] ir_rb;
    logic [3:0] ir_rc;
    logic       op_illegal;
    logic       op_muldiv;
    logic       op_unary;

    assign ir_op = w_IR[31:27];
    assign ir_ra = w_IR[26:23];
    assign ir_rb = w_IR[22:19];
    assign ir_rc = w_IR[18:15];

    assign op_illegal = (ir_op > OP_MAX);
    assign op_muldiv  = (ir_op == OP_MUL) || (ir_op == OP_DIV);
    // Unary ops take their only operand from rb in both T3 and T4.
    assign op_unary   = (ir_op == OP_NOT) || (ir_op == OP_NEG);

    // The low IR bits carry no meaning for this instruction class.
    logic unused_ir_bits;
    assign unused_ir_bits = ^w_IR[14:0];

    // One-hot register decoders. An index at or above NUM_REGS matches no
    // bit, so out-of-range fields select and write nothing.
    logic [NUM_REGS-1:0] ra_hot;
    logic [NUM_REGS-1:0] rb_hot;
    logic [NUM_REGS-1:0] rc_hot;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_dec
            assign ra_hot[gi] = (32'(ir_ra) == gi);
            assign rb_hot[gi] = (32'(ir_rb) == gi);
            assign rc_hot[gi] = (32'(ir_rc) == gi);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register and retired-instruction counter.
    // The counter advances on the edge that enters the final T-state. The
    // new count is then visible in the same cycle as done.
    // -------------------------------------------------------------------------
    always_ff @(posedge w_clock) begin
        if (w_clear) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (w_run) begin
                        state_reg <= ST_T0;
                    end
                end
                ST_T0: state_reg <= ST_T1;
                ST_T1: state_reg <= ST_T2;
                ST_T2: state_reg <= ST_T3;
                ST_T3: begin
                    state_reg <= op_illegal ? ST_ILLEGAL : ST_T4;
                end
                ST_T4: begin
                    state_reg <= ST_T5;
                    if (!op_muldiv) begin
                        count_reg <= count_reg + CNT_ONE;
                    end
                end
                ST_T5: begin
                    if (op_muldiv) begin
                        state_reg <= ST_T6;
                        count_reg <= count_reg + CNT_ONE;
                    end else begin
                        state_reg <= w_run ? ST_T0 : ST_IDLE;
                    end
                end
                ST_T6: begin
                    state_reg <= w_run ? ST_T0 : ST_IDLE;
                end
                ST_ILLEGAL: state_reg <= ST_ILLEGAL;
                default:    state_reg <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Each state asserts at most one bus source.
    // -------------------------------------------------------------------------
    always_comb begin
        s_PC    = 1'b0;
        s_Zlow  = 1'b0;
        s_Zhigh = 1'b0;
        s_MDR   = 1'b0;
        s_Rout  = '0;
        e_Rin   = '0;
        e_MAR   = 1'b0;
        e_Z     = 1'b0;
        e_PC    = 1'b0;
        e_MDR   = 1'b0;
        e_IR    = 1'b0;
        e_Y     = 1'b0;
        e_HI    = 1'b0;
        e_LO    = 1'b0;
        w_IncPC = 1'b0;
        w_read  = 1'b0;
        e_alu   = 1'b0;
        opcode  = 6'd0;
        busy    = 1'b0;
        done    = 1'b0;
        illegal = 1'b0;

        case (state_reg)
            ST_T0: begin
                busy    = 1'b1;
                s_PC    = 1'b1;
                e_MAR   = 1'b1;
                w_IncPC = 1'b1;
                e_Z     = 1'b1;
            end
            ST_T1: begin
                busy   = 1'b1;
                s_Zlow = 1'b1;
                e_PC   = 1'b1;
                w_read = 1'b1;
                e_MDR  = 1'b1;
            end
            ST_T2: begin
                busy  = 1'b1;
                s_MDR = 1'b1;
                e_IR  = 1'b1;
            end
            ST_T3: begin
                busy = 1'b1;
                // An illegal opcode is caught here; nothing is driven so the
                // datapath is left untouched before parking in ILLEGAL.
                if (!op_illegal) begin
                    s_Rout = rb_hot;
                    e_Y    = 1'b1;
                end
            end
            ST_T4: begin
                busy   = 1'b1;
                s_Rout = op_unary ? rb_hot : rc_hot;
                e_alu  = 1'b1;
                e_Z    = 1'b1;
                opcode = {1'b0, ir_op};
            end
            ST_T5: begin
                busy   = 1'b1;
                s_Zlow = 1'b1;
                if (op_muldiv) begin
                    e_LO = 1'b1;
                end else begin
                    e_Rin = ra_hot;
                    done  = 1'b1;
                end
            end
            ST_T6: begin
                busy    = 1'b1;
                s_Zhigh = 1'b1;
                e_HI    = 1'b1;
                done    = 1'b1;
            end
            ST_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign instr_count = count_reg;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_sequencer
//
// Directed-vector bench for alu_ctrl_sequencer. The main instance uses the
// default parameters. A second instance (NUM_REGS=4, CNT_W=2) shares the same
// stimulus. It covers out-of-range register indices and counter wrap.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        w_clear;
    logic        w_run;
    logic [31:0] w_IR;

    always #5 clk = ~clk;

    // main instance outputs
    logic        s_PC, s_Zlow, s_Zhigh, s_MDR;
    logic [15:0] s_Rout, e_Rin;
    logic        e_MAR, e_Z, e_PC, e_MDR, e_IR, e_Y, e_HI, e_LO;
    logic        w_IncPC, w_read, e_alu;
    logic [5:0]  opcode;
    logic        busy, done, illegal;
    logic [15:0] instr_count;

    // small instance outputs
    logic        s_PC_s, s_Zlow_s, s_Zhigh_s, s_MDR_s;
    logic [3:0]  s_Rout_s, e_Rin_s;
    logic        e_MAR_s, e_Z_s, e_PC_s, e_MDR_s, e_IR_s, e_Y_s, e_HI_s, e_LO_s;
    logic        w_IncPC_s, w_read_s, e_alu_s;
    logic [5:0]  opcode_s;
    logic        busy_s, done_s, illegal_s;
    logic [1:0]  instr_count_s;

    alu_ctrl_sequencer #(.NUM_REGS(16), .CNT_W(16)) dut (
        .w_clock(clk), .w_clear(w_clear), .w_run(w_run), .w_IR(w_IR),
        .s_PC(s_PC), .s_Zlow(s_Zlow), .s_Zhigh(s_Zhigh), .s_MDR(s_MDR),
        .s_Rout(s_Rout), .e_Rin(e_Rin),
        .e_MAR(e_MAR), .e_Z(e_Z), .e_PC(e_PC), .e_MDR(e_MDR), .e_IR(e_IR),
        .e_Y(e_Y), .e_HI(e_HI), .e_LO(e_LO),
        .w_IncPC(w_IncPC), .w_read(w_read), .e_alu(e_alu),
        .opcode(opcode), .busy(busy), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    alu_ctrl_sequencer #(.NUM_REGS(4), .CNT_W(2)) dut_s (
        .w_clock(clk), .w_clear(w_clear), .w_run(w_run), .w_IR(w_IR),
        .s_PC(s_PC_s), .s_Zlow(s_Zlow_s), .s_Zhigh(s_Zhigh_s), .s_MDR(s_MDR_s),
        .s_Rout(s_Rout_s), .e_Rin(e_Rin_s),
        .e_MAR(e_MAR_s), .e_Z(e_Z_s), .e_PC(e_PC_s), .e_MDR(e_MDR_s), .e_IR(e_IR_s),
        .e_Y(e_Y_s), .e_HI(e_HI_s), .e_LO(e_LO_s),
        .w_IncPC(w_IncPC_s), .w_read(w_read_s), .e_alu(e_alu_s),
        .opcode(opcode_s), .busy(busy_s), .done(done_s), .illegal(illegal_s),
        .instr_count(instr_count_s)
    );

    // Packed view of the single-bit outputs, MSB first.
    logic [17:0] ctl, ctl_s;
    assign ctl   = {s_PC, s_Zlow, s_Zhigh, s_MDR, e_MAR, e_Z, e_PC, e_MDR, e_IR,
                    e_Y, e_HI, e_LO, w_IncPC, w_read, e_alu, done, busy, illegal};
    assign ctl_s = {s_PC_s, s_Zlow_s, s_Zhigh_s, s_MDR_s, e_MAR_s, e_Z_s, e_PC_s,
                    e_MDR_s, e_IR_s, e_Y_s, e_HI_s, e_LO_s, w_IncPC_s, w_read_s,
                    e_alu_s, done_s, busy_s, illegal_s};

    localparam logic [17:0] B_SPC  = 18'h20000;
    localparam logic [17:0] B_SZL  = 18'h10000;
    localparam logic [17:0] B_SZH  = 18'h08000;
    localparam logic [17:0] B_SMDR = 18'h04000;
    localparam logic [17:0] B_EMAR = 18'h02000;
    localparam logic [17:0] B_EZ   = 18'h01000;
    localparam logic [17:0] B_EPC  = 18'h00800;
    localparam logic [17:0] B_EMDR = 18'h00400;
    localparam logic [17:0] B_EIR  = 18'h00200;
    localparam logic [17:0] B_EY   = 18'h00100;
    localparam logic [17:0] B_EHI  = 18'h00080;
    localparam logic [17:0] B_ELO  = 18'h00040;
    localparam logic [17:0] B_INC  = 18'h00020;
    localparam logic [17:0] B_RD   = 18'h00010;
    localparam logic [17:0] B_ALU  = 18'h00008;
    localparam logic [17:0] B_DONE = 18'h00004;
    localparam logic [17:0] B_BUSY = 18'h00002;
    localparam logic [17:0] B_ILL  = 18'h00001;

    localparam logic [17:0] C_T0  = B_SPC | B_EMAR | B_INC | B_EZ | B_BUSY;
    localparam logic [17:0] C_T1  = B_SZL | B_EPC | B_RD | B_EMDR | B_BUSY;
    localparam logic [17:0] C_T2  = B_SMDR | B_EIR | B_BUSY;
    localparam logic [17:0] C_T3  = B_EY | B_BUSY;
    localparam logic [17:0] C_T4  = B_ALU | B_EZ | B_BUSY;
    localparam logic [17:0] C_T5  = B_SZL | B_DONE | B_BUSY;
    localparam logic [17:0] C_T5M = B_SZL | B_ELO | B_BUSY;
    localparam logic [17:0] C_T6  = B_SZH | B_EHI | B_DONE | B_BUSY;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting from IDLE (or from the final state of the
    // previous one) with w_run already high. rb_sel/t4_sel/rin_sel are the
    // expected one-hot vectors for T3, T4 and T5. If keep_run is 0, w_run is
    // dropped right after T0 to show the instruction still completes.
    task automatic do_instr(input logic [31:0] ir, input logic [15:0] rb_sel,
                            input logic [15:0] t4_sel, input logic [15:0] rin_sel,
                            input logic [5:0] op_exp, input bit md, input bit keep_run);
        w_IR = ir;
        step(); check("T0 ctl", ctl, C_T0);
        w_run = keep_run;
        step(); check("T1 ctl", ctl, C_T1);
        step(); check("T2 ctl", ctl, C_T2);
        step(); check("T3 ctl", ctl, C_T3);
        check("T3 s_Rout", s_Rout, rb_sel);
        step(); check("T4 ctl", ctl, C_T4);
        check("T4 s_Rout", s_Rout, t4_sel);
        check("T4 s_Rout small", s_Rout_s, t4_sel & 16'h000F);
        check("T4 opcode", opcode, op_exp);
        step();
        if (!md) begin
            exp_cnt++;
            check("T5 ctl", ctl, C_T5);
            check("T5 e_Rin", e_Rin, rin_sel);
            check("T5 e_Rin small", e_Rin_s, rin_sel & 16'h000F);
        end else begin
            check("T5 mul/div ctl", ctl, C_T5M);
            check("T5 mul/div e_Rin", e_Rin, 16'h0000);
            step();
            exp_cnt++;
            check("T6 ctl", ctl, C_T6);
        end
        check("instr_count", instr_count, exp_cnt & 32'hFFFF);
        check("instr_count small", instr_count_s, exp_cnt & 32'h3);
        check("ctl small matches", ctl_s, ctl);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w_clear = 1'b1;
        w_run   = 1'b0;
        w_IR    = 32'h0;
        step();
        step();
        check("reset ctl", ctl, 18'h0);
        check("reset count", instr_count, 32'h0);
        check("reset s_Rout", s_Rout, 32'h0);
        check("reset opcode", opcode, 32'h0);
        w_clear = 1'b0;
        step();
        check("idle holds", ctl, 18'h0);

        // add R1,R2,R3
        w_run = 1'b1;
        do_instr(32'h00918000, 16'h0004, 16'h0008, 16'h0002, 6'd0, 1'b0, 1'b0);
        step(); check("idle after add", ctl, 18'h0);

        // shr R1,R2,R3
        w_run = 1'b1;
        do_instr(32'h48918000, 16'h0004, 16'h0008, 16'h0002, 6'd9, 1'b0, 1'b0);
        step(); check("idle after shr", ctl, 18'h0);

        // mul R2,R3: T5 loads LO, T6 loads HI with done
        w_run = 1'b1;
        do_instr(32'h28118000, 16'h0004, 16'h0008, 16'h0000, 6'd5, 1'b1, 1'b0);
        step(); check("idle after mul", ctl, 18'h0);

        // neg R0,R2: unary op uses rb in T4, ra=0 writes R0; small count wraps
        w_run = 1'b1;
        do_instr(32'h60118000, 16'h0004, 16'h0004, 16'h0001, 6'd12, 1'b0, 1'b0);
        step(); check("idle after neg", ctl, 18'h0);

        // add R5,R4,R7: indices beyond the small instance's register file
        w_run = 1'b1;
        do_instr({5'd0, 4'd5, 4'd4, 4'd7, 15'd0}, 16'h0010, 16'h0080, 16'h0020,
                 6'd0, 1'b0, 1'b0);
        step(); check("idle after add hi", ctl, 18'h0);

        // three back-to-back adds, no bubble between T5 and T0
        w_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_instr(32'h00918000, 16'h0004, 16'h0008, 16'h0002, 6'd0, 1'b0, k < 2);
        end
        step(); check("idle after burst", ctl, 18'h0);
        check("burst count", instr_count, 32'd8);

        // clear during T4, with w_run also high: clear wins
        w_run = 1'b1;
        w_IR  = 32'h00918000;
        repeat (5) step();
        check("pre-clear T4 ctl", ctl, C_T4);
        w_clear = 1'b1;
        step();
        exp_cnt = 0;
        check("clear in T4 ctl", ctl, 18'h0);
        check("clear in T4 count", instr_count, 32'h0);
        w_clear = 1'b0;
        w_run   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post-clear e_Rin", e_Rin, 32'h0);
        end

        // one good add, then an illegal opcode
        w_run = 1'b1;
        do_instr(32'h00918000, 16'h0004, 16'h0008, 16'h0002, 6'd0, 1'b0, 1'b1);
        w_IR = 32'hF8000000;
        repeat (4) step();
        check("illegal T3 ctl", ctl, B_BUSY);
        check("illegal T3 s_Rout", s_Rout, 32'h0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("illegal ctl", ctl, B_ILL);
            check("illegal e_Rin", e_Rin | s_Rout, 32'h0);
        end
        check("illegal count held", instr_count, 32'd1);
        w_clear = 1'b1;
        step();
        check("illegal cleared ctl", ctl, 18'h0);
        check("illegal cleared count", instr_count, 32'h0);
        w_clear = 1'b0;

        // opcode 01101, first value past the legal range
        w_IR = 32'h68918000;
        repeat (4) step();
        check("op13 T3 ctl", ctl, B_BUSY);
        step();
        check("op13 illegal", ctl, B_ILL);

        w_run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
